// File: rtl/ext_tx_pkg.sv
// Shared types, AXI encodings and the burst-length helper for the MCHAN
// external TX AXI interface.
package ext_tx_pkg;

  typedef enum logic {
    W_IDLE,
    W_BURST
  } w_state_e;

  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  // Number of data beats minus one for a transfer that starts at byte lane
  // addr_lsb and spans len+1 bytes. The full-width result is returned so the
  // caller can detect values that do not fit an 8-bit AXI length.
  function automatic logic [31:0] beats_f(input logic [7:0]  addr_lsb,
                                          input logic [31:0] len,
                                          input logic [3:0]  off);
    beats_f = (32'(addr_lsb) + len) >> off;
  endfunction

endpackage

// File: rtl/ext_tx_len_fifo.sv
// Burst-length FIFO between the AW and W channels. Each entry is one AW burst
// whose W beats have not yet completed. The head is read straight from the
// storage flops, so a pushed entry becomes visible on the following cycle.
module ext_tx_len_fifo
  import ext_tx_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic [7:0] head,
  output logic       full,
  output logic       empty,
  output logic       last_entry
);

  localparam int PW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign do_push    = push & ~full;
  assign do_pop     = pop & ~empty;
  assign full       = (count == (PW+1)'(DEPTH));
  assign empty      = (count == '0);
  assign last_entry = (count == (PW+1)'(1));
  assign head       = mem[rd_ptr];

  // Storage, pointers and occupancy; a simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/ext_tx_axi_if.sv
// MCHAN external TX interface: turns DMA write commands into AXI4 AW bursts
// and streams TX-buffer beats on W, decoupled by a burst-length FIFO.
// Optional feature macro: EXT_TX_BRESP_ERR_EN adds B-response error reporting.
module ext_tx_axi_if
  import ext_tx_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH  = 32,
  parameter int AXI_DATA_WIDTH  = 64,
  parameter int AXI_ID_WIDTH    = 4,
  parameter int AXI_USER_WIDTH  = 6,
  parameter int EXT_ADD_WIDTH   = 32,
  parameter int EXT_TID_WIDTH   = 4,
  parameter int MCHAN_LEN_WIDTH = 15,
  parameter int LEN_FIFO_DEPTH  = 4,
  parameter int MAX_OUTSND      = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [EXT_ADD_WIDTH-1:0]      cmd_add_i,
  input  logic [MCHAN_LEN_WIDTH-1:0]    cmd_len_i,
  input  logic [EXT_TID_WIDTH-1:0]      cmd_tid_i,
  input  logic                          cmd_bst_i,
  input  logic                          cmd_req_i,
  output logic                          cmd_gnt_o,
  input  logic                          valid_tid_i,
  input  logic [AXI_DATA_WIDTH-1:0]     tx_data_dat_i,
  input  logic [AXI_DATA_WIDTH/8-1:0]   tx_data_strb_i,
  input  logic                          tx_data_gnt_i,
  output logic                          tx_data_req_o,
  output logic                          axi_master_aw_valid_o,
  output logic [AXI_ADDR_WIDTH-1:0]     axi_master_aw_addr_o,
  output logic [2:0]                    axi_master_aw_prot_o,
  output logic [3:0]                    axi_master_aw_region_o,
  output logic [7:0]                    axi_master_aw_len_o,
  output logic [2:0]                    axi_master_aw_size_o,
  output logic [1:0]                    axi_master_aw_burst_o,
  output logic                          axi_master_aw_lock_o,
  output logic [3:0]                    axi_master_aw_cache_o,
  output logic [3:0]                    axi_master_aw_qos_o,
  output logic [AXI_ID_WIDTH-1:0]       axi_master_aw_id_o,
  output logic [AXI_USER_WIDTH-1:0]     axi_master_aw_user_o,
  input  logic                          axi_master_aw_ready_i,
  output logic                          axi_master_w_valid_o,
  output logic [AXI_DATA_WIDTH-1:0]     axi_master_w_data_o,
  output logic [AXI_DATA_WIDTH/8-1:0]   axi_master_w_strb_o,
  output logic [AXI_USER_WIDTH-1:0]     axi_master_w_user_o,
  output logic                          axi_master_w_last_o,
  input  logic                          axi_master_w_ready_i,
  input  logic                          axi_master_b_valid_i,
  input  logic [1:0]                    axi_master_b_resp_i,
  input  logic [AXI_ID_WIDTH-1:0]       axi_master_b_id_i,
  input  logic [AXI_USER_WIDTH-1:0]     axi_master_b_user_i,
  output logic                          axi_master_b_ready_o,
  output logic                          release_tid_o,
  output logic [EXT_TID_WIDTH-1:0]      res_tid_o,
  output logic                          synch_req_o,
`ifdef EXT_TX_BRESP_ERR_EN
  output logic                          err_valid_o,
  output logic [EXT_TID_WIDTH-1:0]      err_tid_o,
  output logic [1:0]                    err_resp_o,
  output logic                          err_sticky_o,
  input  logic                          err_clr_i,
`endif
  output logic                          idle_o
);

  localparam int OFF = $clog2(AXI_DATA_WIDTH/8);
  localparam int OW  = $clog2(MAX_OUTSND+1);

  w_state_e    w_state_q, w_state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [OW-1:0] outsnd_q;
  logic [31:0] aw_len_full;
  logic [7:0]  aw_len;
  logic [7:0]  head_len;
  logic        fifo_full;
  logic        fifo_empty;
  logic        fifo_last_entry;
  logic        fifo_pop;
  logic        aw_valid;
  logic        aw_hs;
  logic        b_hs;
  logic        w_valid;
  logic        w_last;
  logic        unused_ok;

  assign aw_len_full = beats_f(8'(cmd_add_i[OFF-1:0]), 32'(cmd_len_i), 4'(OFF));
  assign aw_len      = aw_len_full[7:0];

  // AW never waits on aw_ready, which keeps the channel AXI-compliant.
  assign aw_valid = cmd_req_i & valid_tid_i & ~fifo_full & (outsnd_q < OW'(MAX_OUTSND));
  assign aw_hs    = aw_valid & axi_master_aw_ready_i;
  assign b_hs     = axi_master_b_valid_i;

  assign cmd_gnt_o              = aw_hs;
  assign axi_master_aw_valid_o  = aw_valid;
  assign axi_master_aw_addr_o   = aw_valid ? AXI_ADDR_WIDTH'(cmd_add_i) : '0;
  assign axi_master_aw_len_o    = aw_valid ? aw_len : '0;
  assign axi_master_aw_size_o   = aw_valid ? 3'(OFF) : '0;
  assign axi_master_aw_burst_o  = !aw_valid ? '0 : (cmd_bst_i ? AXI_BURST_INCR : AXI_BURST_FIXED);
  assign axi_master_aw_id_o     = aw_valid ? AXI_ID_WIDTH'(cmd_tid_i) : '0;
  assign axi_master_aw_prot_o   = '0;
  assign axi_master_aw_region_o = '0;
  assign axi_master_aw_lock_o   = 1'b0;
  assign axi_master_aw_cache_o  = '0;
  assign axi_master_aw_qos_o    = '0;
  assign axi_master_aw_user_o   = '0;

  assign axi_master_w_valid_o = w_valid;
  assign axi_master_w_last_o  = w_last;
  assign axi_master_w_data_o  = tx_data_dat_i;
  assign axi_master_w_strb_o  = tx_data_strb_i;
  assign axi_master_w_user_o  = '0;
  assign tx_data_req_o        = w_valid & axi_master_w_ready_i;

  assign axi_master_b_ready_o = 1'b1;
  assign release_tid_o        = axi_master_b_valid_i;
  assign synch_req_o          = axi_master_b_valid_i;
  assign res_tid_o            = axi_master_b_id_i[EXT_TID_WIDTH-1:0];

  assign idle_o = fifo_empty & (outsnd_q == '0);

  assign unused_ok = ^{axi_master_b_user_i, axi_master_b_id_i, axi_master_b_resp_i};

  ext_tx_len_fifo #(
    .DEPTH (LEN_FIFO_DEPTH)
  ) u_len_fifo (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .push       (aw_hs),
    .din        (aw_len),
    .pop        (fifo_pop),
    .head       (head_len),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .last_entry (fifo_last_entry)
  );

  // Outstanding-write counter; an AW and a B in the same cycle cancel out.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      outsnd_q <= '0;
    end else if (aw_hs && !b_hs) begin
      outsnd_q <= outsnd_q + 1'b1;
    end else if (!aw_hs && b_hs && (outsnd_q != '0)) begin
      outsnd_q <= outsnd_q - 1'b1;
    end
  end

  // W channel state and beat-counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      w_state_q <= W_IDLE;
      cnt_q     <= '0;
    end else begin
      w_state_q <= w_state_d;
      cnt_q     <= cnt_d;
    end
  end

  // W channel sequencing: count beats of the head burst, pop it on the last beat.
  always_comb begin
    w_state_d = w_state_q;
    cnt_d     = cnt_q;
    w_valid   = 1'b0;
    w_last    = 1'b0;
    fifo_pop  = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        if (!fifo_empty) w_state_d = W_BURST;
      end
      W_BURST: begin
        w_valid = tx_data_gnt_i;
        w_last  = w_valid & (cnt_q == head_len);
        if (w_valid && axi_master_w_ready_i) begin
          if (cnt_q == head_len) begin
            cnt_d    = '0;
            fifo_pop = 1'b1;
            if (fifo_last_entry && !aw_hs) w_state_d = W_IDLE;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

`ifdef EXT_TX_BRESP_ERR_EN
  logic b_err;
  assign b_err = axi_master_b_valid_i & axi_master_b_resp_i[1];

  // Error capture: one-cycle pulse with TID/resp, sticky flag where a new error beats a clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_valid_o  <= 1'b0;
      err_tid_o    <= '0;
      err_resp_o   <= '0;
      err_sticky_o <= 1'b0;
    end else begin
      err_valid_o <= b_err;
      if (b_err) begin
        err_tid_o  <= axi_master_b_id_i[EXT_TID_WIDTH-1:0];
        err_resp_o <= axi_master_b_resp_i;
      end
      if (b_err)          err_sticky_o <= 1'b1;
      else if (err_clr_i) err_sticky_o <= 1'b0;
    end
  end
`endif

  // A burst longer than 256 beats cannot be expressed on AW.
  a_len_fits : assert property (@(posedge clk_i) disable iff (!rst_ni)
                                aw_valid |-> (aw_len_full <= 32'd255));

endmodule

// File: tb/tb_ext_tx_axi_if.sv
// Directed self-checking bench for ext_tx_axi_if: a default 64-bit instance
// and a 128-bit instance with MAX_OUTSND=2 for the outstanding-limit checks.
module tb_ext_tx_axi_if;

  logic clk = 1'b0;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;
  int   beats;

  // shared inputs
  logic [31:0] cmd_add;
  logic [14:0] cmd_len;
  logic [3:0]  cmd_tid;
  logic        cmd_bst;
  logic        valid_tid;
  logic        aw_ready;
  logic        w_ready;
  logic [1:0]  b_resp;
  logic [3:0]  b_id;
  logic [5:0]  b_user;
  logic        err_clr;

  // dut_a signals (64-bit)
  logic        cmd_req, cmd_gnt;
  logic [63:0] tx_dat;
  logic [7:0]  tx_strb;
  logic        tx_gnt, tx_req;
  logic        aw_valid, aw_lock;
  logic [31:0] aw_addr;
  logic [2:0]  aw_prot, aw_size;
  logic [3:0]  aw_region, aw_cache, aw_qos, aw_id;
  logic [7:0]  aw_len;
  logic [1:0]  aw_burst;
  logic [5:0]  aw_user, w_user;
  logic        w_valid, w_last;
  logic [63:0] w_data;
  logic [7:0]  w_strb;
  logic        b_valid, b_ready, release_tid, synch_req, idle;
  logic [3:0]  res_tid;

  // dut_b signals (128-bit, MAX_OUTSND=2)
  logic         bb_req, bb_gnt;
  logic [31:0]  bb_add;
  logic [14:0]  bb_len;
  logic [127:0] bb_tx_dat;
  logic [15:0]  bb_tx_strb;
  logic         bb_tx_gnt, bb_tx_req;
  logic         bb_aw_valid, bb_aw_lock;
  logic [31:0]  bb_aw_addr;
  logic [2:0]   bb_aw_prot, bb_aw_size;
  logic [3:0]   bb_aw_region, bb_aw_cache, bb_aw_qos, bb_aw_id;
  logic [7:0]   bb_aw_len;
  logic [1:0]   bb_aw_burst;
  logic [5:0]   bb_aw_user, bb_w_user;
  logic         bb_w_valid, bb_w_last;
  logic [127:0] bb_w_data;
  logic [15:0]  bb_w_strb;
  logic         bb_b_valid, bb_b_ready, bb_release, bb_synch, bb_idle;
  logic [3:0]   bb_res_tid;

`ifdef EXT_TX_BRESP_ERR_EN
  logic       err_valid, err_sticky, bb_err_valid, bb_err_sticky;
  logic [3:0] err_tid, bb_err_tid;
  logic [1:0] err_resp, bb_err_resp;
`endif

  always #5 clk = ~clk;

  ext_tx_axi_if dut_a (
    .clk_i(clk), .rst_ni(rst_n),
    .cmd_add_i(cmd_add), .cmd_len_i(cmd_len), .cmd_tid_i(cmd_tid), .cmd_bst_i(cmd_bst),
    .cmd_req_i(cmd_req), .cmd_gnt_o(cmd_gnt), .valid_tid_i(valid_tid),
    .tx_data_dat_i(tx_dat), .tx_data_strb_i(tx_strb), .tx_data_gnt_i(tx_gnt), .tx_data_req_o(tx_req),
    .axi_master_aw_valid_o(aw_valid), .axi_master_aw_addr_o(aw_addr), .axi_master_aw_prot_o(aw_prot),
    .axi_master_aw_region_o(aw_region), .axi_master_aw_len_o(aw_len), .axi_master_aw_size_o(aw_size),
    .axi_master_aw_burst_o(aw_burst), .axi_master_aw_lock_o(aw_lock), .axi_master_aw_cache_o(aw_cache),
    .axi_master_aw_qos_o(aw_qos), .axi_master_aw_id_o(aw_id), .axi_master_aw_user_o(aw_user),
    .axi_master_aw_ready_i(aw_ready),
    .axi_master_w_valid_o(w_valid), .axi_master_w_data_o(w_data), .axi_master_w_strb_o(w_strb),
    .axi_master_w_user_o(w_user), .axi_master_w_last_o(w_last), .axi_master_w_ready_i(w_ready),
    .axi_master_b_valid_i(b_valid), .axi_master_b_resp_i(b_resp), .axi_master_b_id_i(b_id),
    .axi_master_b_user_i(b_user), .axi_master_b_ready_o(b_ready),
    .release_tid_o(release_tid), .res_tid_o(res_tid), .synch_req_o(synch_req),
`ifdef EXT_TX_BRESP_ERR_EN
    .err_valid_o(err_valid), .err_tid_o(err_tid), .err_resp_o(err_resp),
    .err_sticky_o(err_sticky), .err_clr_i(err_clr),
`endif
    .idle_o(idle)
  );

  ext_tx_axi_if #(.AXI_DATA_WIDTH(128), .MAX_OUTSND(2), .LEN_FIFO_DEPTH(8)) dut_b (
    .clk_i(clk), .rst_ni(rst_n),
    .cmd_add_i(bb_add), .cmd_len_i(bb_len), .cmd_tid_i(cmd_tid), .cmd_bst_i(cmd_bst),
    .cmd_req_i(bb_req), .cmd_gnt_o(bb_gnt), .valid_tid_i(valid_tid),
    .tx_data_dat_i(bb_tx_dat), .tx_data_strb_i(bb_tx_strb), .tx_data_gnt_i(bb_tx_gnt), .tx_data_req_o(bb_tx_req),
    .axi_master_aw_valid_o(bb_aw_valid), .axi_master_aw_addr_o(bb_aw_addr), .axi_master_aw_prot_o(bb_aw_prot),
    .axi_master_aw_region_o(bb_aw_region), .axi_master_aw_len_o(bb_aw_len), .axi_master_aw_size_o(bb_aw_size),
    .axi_master_aw_burst_o(bb_aw_burst), .axi_master_aw_lock_o(bb_aw_lock), .axi_master_aw_cache_o(bb_aw_cache),
    .axi_master_aw_qos_o(bb_aw_qos), .axi_master_aw_id_o(bb_aw_id), .axi_master_aw_user_o(bb_aw_user),
    .axi_master_aw_ready_i(aw_ready),
    .axi_master_w_valid_o(bb_w_valid), .axi_master_w_data_o(bb_w_data), .axi_master_w_strb_o(bb_w_strb),
    .axi_master_w_user_o(bb_w_user), .axi_master_w_last_o(bb_w_last), .axi_master_w_ready_i(w_ready),
    .axi_master_b_valid_i(bb_b_valid), .axi_master_b_resp_i(b_resp), .axi_master_b_id_i(b_id),
    .axi_master_b_user_i(b_user), .axi_master_b_ready_o(bb_b_ready),
    .release_tid_o(bb_release), .res_tid_o(bb_res_tid), .synch_req_o(bb_synch),
`ifdef EXT_TX_BRESP_ERR_EN
    .err_valid_o(bb_err_valid), .err_tid_o(bb_err_tid), .err_resp_o(bb_err_resp),
    .err_sticky_o(bb_err_sticky), .err_clr_i(err_clr),
`endif
    .idle_o(bb_idle)
  );

  // Drive one command onto dut_a's command port.
  task automatic applyStimulus(input logic [31:0] add, input logic [14:0] len, input logic [3:0] tid);
    cmd_add = add;
    cmd_len = len;
    cmd_tid = tid;
    cmd_req = 1'b1;
  endtask

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    cmd_add = '0; cmd_len = '0; cmd_tid = '0; cmd_bst = 1'b1; cmd_req = 1'b0;
    valid_tid = 1'b1; aw_ready = 1'b1; w_ready = 1'b1;
    b_resp = '0; b_id = '0; b_user = '0; err_clr = 1'b0; b_valid = 1'b0;
    tx_dat = '0; tx_strb = '0; tx_gnt = 1'b0;
    bb_req = 1'b0; bb_add = '0; bb_len = '0; bb_tx_dat = '0; bb_tx_strb = '0; bb_tx_gnt = 1'b0;
    bb_b_valid = 1'b0;

    // reset state
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst_idle", idle, 1);
    checkOutput("rst_b_ready", b_ready, 1);
    checkOutput("rst_aw_valid", aw_valid, 0);
    checkOutput("rst_w_valid", w_valid, 0);
    checkOutput("rst_tx_req", tx_req, 0);
    checkOutput("rst_release", release_tid, 0);
    checkOutput("rst_cmd_gnt", cmd_gnt, 0);
`ifdef EXT_TX_BRESP_ERR_EN
    checkOutput("rst_err_sticky", err_sticky, 0);
    checkOutput("rst_err_valid", err_valid, 0);
`endif
    rst_n = 1'b1;

    // single-beat burst: add=0x1000 len=7 -> aw_len 0
    @(negedge clk);
    applyStimulus(32'h1000, 15'd7, 4'd3);
    #1;
    checkOutput("t1_aw_valid", aw_valid, 1);
    checkOutput("t1_cmd_gnt", cmd_gnt, 1);
    checkOutput("t1_aw_addr", aw_addr, 64'h1000);
    checkOutput("t1_aw_len", aw_len, 0);
    checkOutput("t1_aw_size", aw_size, 3);
    checkOutput("t1_aw_burst", aw_burst, 1);
    checkOutput("t1_aw_id", aw_id, 3);
    @(negedge clk);
    cmd_req = 1'b0; tx_gnt = 1'b1; tx_dat = 64'hA5A5_0000_1111_2222; tx_strb = 8'hFF;
    #1;
    checkOutput("t1_w_latency", w_valid, 0);
    checkOutput("t1_busy", idle, 0);
    @(negedge clk);
    #1;
    checkOutput("t1_w_valid", w_valid, 1);
    checkOutput("t1_w_last", w_last, 1);
    checkOutput("t1_tx_req", tx_req, 1);
    checkOutput("t1_w_data", w_data, 64'hA5A5_0000_1111_2222);
    @(negedge clk);
    tx_gnt = 1'b0; b_valid = 1'b1; b_id = 4'd3;
    #1;
    checkOutput("t1_w_done", w_valid, 0);
    checkOutput("t1_release", release_tid, 1);
    checkOutput("t1_res_tid", res_tid, 3);
    checkOutput("t1_synch", synch_req, 1);
    @(negedge clk);
    b_valid = 1'b0;
    #1;
    checkOutput("t1_idle", idle, 1);
    checkOutput("t1_release_off", release_tid, 0);

    // misaligned: add=0x1004 len=7 -> aw_len 1, last on 2nd beat
    @(negedge clk);
    applyStimulus(32'h1004, 15'd7, 4'd2);
    #1;
    checkOutput("t2_aw_len", aw_len, 1);
    @(negedge clk);
    cmd_req = 1'b0;
    @(negedge clk);
    tx_gnt = 1'b1;
    #1;
    checkOutput("t2_beat1_valid", w_valid, 1);
    checkOutput("t2_beat1_last", w_last, 0);
    @(negedge clk);
    #1;
    checkOutput("t2_beat2_valid", w_valid, 1);
    checkOutput("t2_beat2_last", w_last, 1);
    @(negedge clk);
    tx_gnt = 1'b0; b_valid = 1'b1; b_id = 4'd2;
    #1;
    checkOutput("t2_res_tid", res_tid, 2);
    @(negedge clk);
    b_valid = 1'b0;

    // 3-beat burst with TX-buffer gaps and a W stall
    @(negedge clk);
    applyStimulus(32'h0, 15'd23, 4'd4);
    #1;
    checkOutput("t3_aw_len", aw_len, 2);
    @(negedge clk);
    cmd_req = 1'b0;
    @(negedge clk);
    tx_gnt = 1'b1; tx_dat = 64'h1;
    #1;
    checkOutput("t3_b1_last", w_last, 0);
    checkOutput("t3_b1_req", tx_req, 1);
    @(negedge clk);
    tx_gnt = 1'b0;
    #1;
    checkOutput("t3_gap1_valid", w_valid, 0);
    @(negedge clk);
    tx_gnt = 1'b1; w_ready = 1'b0; tx_dat = 64'h2;
    #1;
    checkOutput("t3_stall_valid", w_valid, 1);
    checkOutput("t3_stall_req", tx_req, 0);
    checkOutput("t3_stall_last", w_last, 0);
    @(negedge clk);
    w_ready = 1'b1;
    #1;
    checkOutput("t3_b2_last", w_last, 0);
    checkOutput("t3_b2_data", w_data, 64'h2);
    @(negedge clk);
    tx_gnt = 1'b0;
    #1;
    checkOutput("t3_gap2_valid", w_valid, 0);
    @(negedge clk);
    tx_gnt = 1'b1; tx_dat = 64'h3;
    #1;
    checkOutput("t3_b3_last", w_last, 1);
    @(negedge clk);
    tx_gnt = 1'b0; b_valid = 1'b1; b_id = 4'd4;
    @(negedge clk);
    b_valid = 1'b0;
    #1;
    checkOutput("t3_idle", idle, 1);

    // FIFO full: 5 commands while W is stalled -> 4 accepted, 5th waits
    @(negedge clk);
    applyStimulus(32'h2000, 15'd7, 4'd6);
    for (int i = 0; i < 4; i++) begin
      #1;
      checkOutput("t4_aw_accept", aw_valid, 1);
      @(negedge clk);
    end
    #1;
    checkOutput("t4_full_block", aw_valid, 0);
    @(negedge clk);
    tx_gnt = 1'b1; tx_dat = 64'h55;
    #1;
    checkOutput("t4_full_hold", aw_valid, 0);
    checkOutput("t4_first_last", w_last, 1);
    beats = (tx_req && w_last) ? 1 : 0;
    @(negedge clk);
    #1;
    checkOutput("t4_slot_freed", aw_valid, 1);
    checkOutput("t4_back2back", tx_req, 1);
    if (tx_req && w_last) beats++;
    @(negedge clk);
    cmd_req = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (tx_req && w_last) beats++;
      @(negedge clk);
    end
    tx_gnt = 1'b0;
    checkOutput("t4_beats", beats, 5);

    // five B responses, the first one an error response
    b_valid = 1'b1; b_resp = 2'b10; b_id = 4'd5;
    #1;
    checkOutput("t4_b_res_tid", res_tid, 5);
    @(negedge clk);
    b_resp = 2'b00; b_id = 4'd6;
`ifdef EXT_TX_BRESP_ERR_EN
    #1;
    checkOutput("err_valid", err_valid, 1);
    checkOutput("err_tid", err_tid, 5);
    checkOutput("err_resp", err_resp, 2);
    checkOutput("err_sticky_set", err_sticky, 1);
`endif
    @(negedge clk);
`ifdef EXT_TX_BRESP_ERR_EN
    #1;
    checkOutput("err_pulse_end", err_valid, 0);
    checkOutput("err_sticky_hold", err_sticky, 1);
`endif
    repeat (2) @(negedge clk);
    #1;
    checkOutput("t4_outsnd_one", idle, 0);
    @(negedge clk);
    b_valid = 1'b0;
    #1;
    checkOutput("t4_idle", idle, 1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
`ifdef EXT_TX_BRESP_ERR_EN
    #1;
    checkOutput("err_sticky_clr", err_sticky, 0);
`endif

    // 128-bit instance, MAX_OUTSND=2
    @(negedge clk);
    bb_add = 32'h0; bb_len = 15'd255; bb_req = 1'b1; cmd_tid = 4'd1;
    #1;
    checkOutput("t5_aw_valid", bb_aw_valid, 1);
    checkOutput("t5_aw_len", bb_aw_len, 15);
    checkOutput("t5_aw_size", bb_aw_size, 4);
    @(negedge clk);
    #1;
    checkOutput("t5_second_aw", bb_aw_valid, 1);
    @(negedge clk);
    #1;
    checkOutput("t5_third_blocked", bb_aw_valid, 0);
    bb_b_valid = 1'b1;
    @(negedge clk);
    #1;
    checkOutput("t5_after_b", bb_aw_valid, 1);
    @(negedge clk);
    bb_b_valid = 1'b0;
    #1;
    checkOutput("t5_aw_b_same", bb_aw_valid, 1);
    @(negedge clk);
    #1;
    checkOutput("t5_limit_again", bb_aw_valid, 0);
    bb_req = 1'b0;

    // reset asserted in the middle of a burst
    @(negedge clk);
    applyStimulus(32'h0, 15'd23, 4'd7);
    @(negedge clk);
    cmd_req = 1'b0;
    @(negedge clk);
    tx_gnt = 1'b1;
    @(negedge clk);
    #1;
    checkOutput("t6_mid_burst", w_valid, 1);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("t6_rst_w_valid", w_valid, 0);
    checkOutput("t6_rst_tx_req", tx_req, 0);
    checkOutput("t6_rst_w_last", w_last, 0);
    checkOutput("t6_rst_idle", idle, 1);
    checkOutput("t6_rst_b_ready", b_ready, 1);
    checkOutput("t6_rst_bb_idle", bb_idle, 1);
    tx_gnt = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    checkOutput("t6_post_idle", idle, 1);
    checkOutput("t6_post_w_valid", w_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
